result_collector: RTL and testbench

Downstream capture stage for the 2x2 matrix unit. Samples the two result lanes (out1/out2) on each valid strobe into a small FIFO of lane pairs. Tracks job completion from the unit's done flag. Exposes results and status to the host through an APB slave, so the host drains results with ordinary APB reads after done.

---
 rtl/result_collector_pkg.sv | 54 +++++
 rtl/result_collector_fifo.sv | 73 +++++++
 rtl/result_collector.sv | 157 +++++++++++++++
 tb/tb_result_collector.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: register map, bit positions
// inside STATUS/CTRL, and widths derived from the FIFO depth.
package result_collector_pkg;

  // Register offsets relative to the APB base address
  localparam logic [31:0] OFF_DATA_LO  = 32'h00;
  localparam logic [31:0] OFF_DATA_HI  = 32'h04;
  localparam logic [31:0] OFF_STATUS   = 32'h08;
  localparam logic [31:0] OFF_CTRL     = 32'h0C;
  localparam logic [31:0] OFF_DONE_CNT = 32'h10;

  // STATUS bit positions ([7:0] is the entry count)
  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_UNF   = 11;
  localparam int ST_DONE  = 12;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_FLUSH    = 1;
  localparam int CTRL_CLR_DONE = 2;

  typedef enum logic [2:0] {
    SEL_DATA_LO,
    SEL_DATA_HI,
    SEL_STATUS,
    SEL_CTRL,
    SEL_DONE_CNT,
    SEL_NONE
  } reg_sel_e;

  // Pointer width for a power-of-two depth; the count needs one extra bit
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Map a base-relative offset to a register select
  function automatic reg_sel_e decode_reg(input logic [31:0] off);
    case (off)
      OFF_DATA_LO:  return SEL_DATA_LO;
      OFF_DATA_HI:  return SEL_DATA_HI;
      OFF_STATUS:   return SEL_STATUS;
      OFF_CTRL:     return SEL_CTRL;
      OFF_DONE_CNT: return SEL_DONE_CNT;
      default:      return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/result_collector_fifo.sv
// Lane-pair FIFO: push/pop/flush with same-cycle push+pop, registered flags.
module result_fifo
  import result_collector_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  logic [WIDTH-1:0]          i_wdata,
  output logic [WIDTH-1:0]          o_rdata,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_pop_ok;
  logic             w_push_ok;
  logic [CNT_W-1:0] w_count_nxt;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is popped at the same time.
  assign w_pop_ok  = i_pop & ~r_empty;
  assign w_push_ok = i_push & (~r_full | w_pop_ok);

  // Next occupancy drives the registered full/empty flags
  always_comb begin
    w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
  end

  // Storage write; flush discards a coinciding push
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, count and flags
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/result_collector.sv
// Captures matrix-unit result lane pairs into a FIFO and exposes results,
// status and job-completion tracking to the host through an APB slave.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h100
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_out1,
  input  logic [DATA_W-1:0] i_out2,
  input  logic              i_valid,
  input  logic              i_done,
  input  logic [31:0]       i_paddr,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [31:0]       i_pwdata,
  output logic [31:0]       o_prdata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_irq
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [2*DATA_W-1:0] w_head;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;

  logic [31:0]         w_off;
  reg_sel_e            w_sel;
  logic                w_setup;
  logic                w_access;
  logic                w_rd_hi;
  logic                w_wr_ctrl;
  logic                w_flush;
  logic                w_clr_done;
  logic                w_pop_taken;
  logic                w_push;
  logic                w_rise;
  logic                w_pending_nxt;
  logic                w_irq_en_nxt;
  logic [31:0]         w_status;
  logic [31:0]         w_rdata;
  logic                w_unused;

  logic                r_done_q;
  logic                r_pending;
  logic                r_irq_en;
  logic                r_ovf;
  logic                r_unf;
  logic [7:0]          r_done_cnt;
  logic                r_irq;
  logic [31:0]         r_prdata;

  assign w_off    = i_paddr - BASE_ADDR;
  assign w_sel    = decode_reg(w_off);
  assign w_setup  = i_psel & ~i_penable & ~i_pwrite;
  assign w_access = i_psel & i_penable;

  assign w_rd_hi    = w_access & ~i_pwrite & (w_sel == SEL_DATA_HI);
  assign w_wr_ctrl  = w_access & i_pwrite & (w_sel == SEL_CTRL);
  assign w_flush    = w_wr_ctrl & i_pwdata[CTRL_FLUSH];
  assign w_clr_done = w_wr_ctrl & i_pwdata[CTRL_CLR_DONE];

  // Flush wins over a coinciding push; the dropped push is not an overflow
  assign w_pop_taken = w_rd_hi & ~w_empty;
  assign w_push      = i_valid & ~w_flush;

  assign w_rise        = i_done & ~r_done_q;
  assign w_pending_nxt = w_rise ? 1'b1 : (w_clr_done ? 1'b0 : r_pending);
  assign w_irq_en_nxt  = w_wr_ctrl ? i_pwdata[CTRL_IRQ_EN] : r_irq_en;

  // Only the defined CTRL bits are consumed from the write data
  assign w_unused = ^i_pwdata[31:3];

  result_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_rd_hi),
    .i_flush (w_flush),
    .i_wdata ({i_out2, i_out1}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Register read mux; head lanes read as 0 when nothing is held
  always_comb begin
    w_status           = '0;
    w_status[7:0]      = 8'(w_count);
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_UNF]   = r_unf;
    w_status[ST_DONE]  = r_pending;
    w_rdata            = '0;
    case (w_sel)
      SEL_DATA_LO:  w_rdata = w_empty ? 32'h0 : 32'(w_head[DATA_W-1:0]);
      SEL_DATA_HI:  w_rdata = w_empty ? 32'h0 : 32'(w_head[2*DATA_W-1:DATA_W]);
      SEL_STATUS:   w_rdata = w_status;
      SEL_CTRL:     w_rdata = {31'h0, r_irq_en};
      SEL_DONE_CNT: w_rdata = {24'h0, r_done_cnt};
      default:      w_rdata = '0;
    endcase
  end

  // Read data is captured in the setup phase and held through the access phase
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prdata <= '0;
    end else if (w_setup) begin
      r_prdata <= w_rdata;
    end
  end

  // Sticky flags, control bits, done edge detect and completion counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done_q   <= 1'b0;
      r_pending  <= 1'b0;
      r_irq_en   <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_done_cnt <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_done_q  <= i_done;
      r_pending <= w_pending_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_irq     <= w_pending_nxt & w_irq_en_nxt;
      if (w_rise) r_done_cnt <= r_done_cnt + 8'd1;
      if (w_flush) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        if (i_valid && w_full && !w_pop_taken) r_ovf <= 1'b1;
        if (w_rd_hi && w_empty)                r_unf <= 1'b1;
      end
    end
  end

  assign o_prdata = r_prdata;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_irq    = r_irq;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed vector table, hand-written corner
// sequences and a randomized phase checked against a queue-based model.
module tb_result_collector;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] BASE   = 32'h100;
  localparam logic [31:0] A_LO   = BASE + 32'h00;
  localparam logic [31:0] A_HI   = BASE + 32'h04;
  localparam logic [31:0] A_ST   = BASE + 32'h08;
  localparam logic [31:0] A_CTRL = BASE + 32'h0C;
  localparam logic [31:0] A_DCNT = BASE + 32'h10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] i_out1 = '0;
  logic [DATA_W-1:0] i_out2 = '0;
  logic              i_valid = 1'b0;
  logic              i_done = 1'b0;
  logic [31:0]       i_paddr = '0;
  logic              i_psel = 1'b0;
  logic              i_penable = 1'b0;
  logic              i_pwrite = 1'b0;
  logic [31:0]       i_pwdata = '0;
  logic [31:0]       o_prdata;
  logic              o_full;
  logic              o_empty;
  logic              o_irq;

  result_collector #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_out1    (i_out1),
    .i_out2    (i_out2),
    .i_valid   (i_valid),
    .i_done    (i_done),
    .i_paddr   (i_paddr),
    .i_psel    (i_psel),
    .i_penable (i_penable),
    .i_pwrite  (i_pwrite),
    .i_pwdata  (i_pwdata),
    .o_prdata  (o_prdata),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_irq     (o_irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit rnd_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: a queue of lane pairs plus the flag/counter rules
  logic [63:0] mq[$];
  bit          m_ovf, m_unf, m_pend, m_irq_en, m_done_q;
  logic [7:0]  m_dcnt;
  logic [31:0] m_prdata;

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    case (off)
      32'h00:  return (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
      32'h04:  return (mq.size() > 0) ? mq[0][63:32] : 32'h0;
      32'h08:  return {19'h0, m_pend, m_unf, m_ovf, (mq.size() == DEPTH), (mq.size() == 0), 8'(mq.size())};
      32'h0C:  return {31'h0, m_irq_en};
      32'h10:  return {24'h0, m_dcnt};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit rd_hi, wr_ctrl, flush, clr, rise;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_pend = 0; m_irq_en = 0; m_done_q = 0;
      m_dcnt = 0; m_prdata = 0;
      return;
    end
    if (i_psel && !i_penable && !i_pwrite) m_prdata = m_read(i_paddr);
    rd_hi   = i_psel && i_penable && !i_pwrite && (i_paddr == A_HI);
    wr_ctrl = i_psel && i_penable && i_pwrite && (i_paddr == A_CTRL);
    flush   = wr_ctrl && i_pwdata[1];
    clr     = wr_ctrl && i_pwdata[2];
    rise    = i_done && !m_done_q;
    m_done_q = i_done;
    if (flush) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (rd_hi) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_unf = 1;
      end
      if (i_valid) begin
        if (mq.size() < DEPTH) mq.push_back({i_out2, i_out1});
        else m_ovf = 1;
      end
    end
    if (wr_ctrl) m_irq_en = i_pwdata[0];
    if (rise) begin
      m_pend = 1;
      m_dcnt = m_dcnt + 8'd1;
    end else if (clr) begin
      m_pend = 0;
    end
  endtask

  always @(posedge clk) model_step();

  // One cycle: advance to the falling edge; in random mode check the flags
  // against the model and re-randomize the result-side inputs.
  task automatic cyc();
    @(negedge clk);
    if (rnd_on) begin
      check("rnd_full",  {31'h0, o_full},  {31'h0, (mq.size() == DEPTH)});
      check("rnd_empty", {31'h0, o_empty}, {31'h0, (mq.size() == 0)});
      check("rnd_irq",   {31'h0, o_irq},   {31'h0, (m_pend && m_irq_en)});
      i_valid = ($urandom_range(0, 1) == 1);
      i_out1  = $urandom;
      i_out2  = $urandom;
      if ($urandom_range(0, 3) == 0) i_done = ~i_done;
    end
  endtask

  task automatic idle();
    cyc();
    i_psel = 0; i_penable = 0; i_pwrite = 0;
    if (!rnd_on) i_valid = 0;
  endtask

  task automatic push(input logic [31:0] l1, input logic [31:0] l2);
    cyc();
    i_psel = 0; i_penable = 0; i_pwrite = 0;
    i_valid = 1; i_out1 = l1; i_out2 = l2;
  endtask

  // Setup then access phase; data is sampled during the access phase.
  // Optionally pushes a lane pair in the access cycle.
  task automatic apb_read(input logic [31:0] addr, output logic [31:0] d,
                          input bit pu = 0, input logic [31:0] l1 = 0, input logic [31:0] l2 = 0);
    cyc();
    i_psel = 1; i_penable = 0; i_pwrite = 0; i_paddr = addr;
    if (!rnd_on) i_valid = 0;
    cyc();
    i_penable = 1;
    if (!rnd_on) begin
      i_valid = pu; i_out1 = l1; i_out2 = l2;
    end
    d = o_prdata;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    cyc();
    i_psel = 1; i_penable = 0; i_pwrite = 1; i_paddr = addr; i_pwdata = data;
    if (!rnd_on) i_valid = 0;
    cyc();
    i_penable = 1;
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    cyc();
    rst = 1; i_psel = 0; i_penable = 0; i_valid = 0; i_done = 0;
    cyc();
    rst = 0;
  endtask

  typedef struct {
    int          op;   // 0 push {a,b}, 1 read a expect exp, 2 write a <- b
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] d;
    logic [31:0] addrs [8];

    tbl[0]  = '{0, 32'd1,      32'd2,     32'h0};
    tbl[1]  = '{0, 32'd3,      32'd4,     32'h0};
    tbl[2]  = '{1, A_LO,       32'h0,     32'd1};
    tbl[3]  = '{1, A_HI,       32'h0,     32'd2};
    tbl[4]  = '{1, A_LO,       32'h0,     32'd3};
    tbl[5]  = '{1, A_HI,       32'h0,     32'd4};
    tbl[6]  = '{1, A_ST,       32'h0,     32'h100};
    tbl[7]  = '{1, A_HI,       32'h0,     32'h0};
    tbl[8]  = '{1, A_ST,       32'h0,     32'h900};
    tbl[9]  = '{2, A_CTRL,     32'h2,     32'h0};
    tbl[10] = '{1, A_ST,       32'h0,     32'h100};
    tbl[11] = '{1, BASE+32'h14, 32'h0,    32'h0};
    tbl[12] = '{2, A_LO,       32'hFFFF,  32'h0};
    tbl[13] = '{2, BASE+32'h20, 32'h7,    32'h0};
    tbl[14] = '{1, A_CTRL,     32'h0,     32'h0};
    tbl[15] = '{1, A_ST,       32'h0,     32'h100};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_empty",  {31'h0, o_empty}, 32'h1);
    check("rst_full",   {31'h0, o_full},  32'h0);
    check("rst_irq",    {31'h0, o_irq},   32'h0);
    check("rst_prdata", o_prdata,         32'h0);

    // Vector table: basic push/read order, underflow, unmapped accesses
    for (int i = 0; i < 16; i++) begin
      case (tbl[i].op)
        0: push(tbl[i].a, tbl[i].b);
        1: begin
          apb_read(tbl[i].a, d);
          check($sformatf("vec%0d", i), d, tbl[i].exp);
        end
        default: apb_write(tbl[i].a, tbl[i].b);
      endcase
    end

    // Overflow: nine pushes into eight entries, the ninth is lost
    for (int k = 1; k <= 9; k++) push(k, k + 100);
    read_chk("ovf_status", A_ST, 32'h608);
    check("ovf_full_pin", {31'h0, o_full}, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      read_chk($sformatf("ovf_lo%0d", k), A_LO, k);
      read_chk($sformatf("ovf_hi%0d", k), A_HI, k + 100);
    end
    read_chk("ovf_after_drain", A_ST, 32'h500);
    apb_write(A_CTRL, 32'h2);
    read_chk("flush_status", A_ST, 32'h100);

    // Full FIFO: push in the same cycle as a DATA_HI pop
    for (int k = 1; k <= 8; k++) push(k, k + 200);
    apb_read(A_HI, d, 1, 32'hAA, 32'hBB);
    check("pp_hi", d, 32'd201);
    read_chk("pp_status", A_ST, 32'h208);
    for (int k = 2; k <= 8; k++) begin
      read_chk($sformatf("pp_lo%0d", k), A_LO, k);
      read_chk($sformatf("pp_hi%0d", k), A_HI, k + 200);
    end
    read_chk("pp_last_lo", A_LO, 32'hAA);
    read_chk("pp_last_hi", A_HI, 32'hBB);
    read_chk("pp_end", A_ST, 32'h100);

    // Done tracking: two 3-cycle pulses count twice and raise the irq
    apb_write(A_CTRL, 32'h1);
    repeat (2) begin
      repeat (3) begin idle(); i_done = 1; end
      repeat (2) begin idle(); i_done = 0; end
    end
    read_chk("done_cnt", A_DCNT, 32'd2);
    idle();
    check("irq_set", {31'h0, o_irq}, 32'h1);
    read_chk("done_status", A_ST, 32'h1100);
    apb_write(A_CTRL, 32'h5);
    idle();
    check("irq_clr", {31'h0, o_irq}, 32'h0);
    read_chk("irq_en_kept", A_CTRL, 32'h1);
    read_chk("done_cnt_kept", A_DCNT, 32'd2);

    // Reset mid-stream with three entries held
    for (int k = 1; k <= 3; k++) push(k, k);
    read_chk("pre_rst_status", A_ST, 32'h003);
    do_reset();
    check("mid_rst_empty",  {31'h0, o_empty}, 32'h1);
    check("mid_rst_prdata", o_prdata,         32'h0);
    read_chk("mid_rst_status", A_ST, 32'h100);
    read_chk("mid_rst_dcnt", A_DCNT, 32'h0);
    read_chk("mid_rst_ctrl", A_CTRL, 32'h0);

    // Randomized traffic against the model
    addrs[0] = A_LO;  addrs[1] = A_HI;  addrs[2] = A_HI;   addrs[3] = A_ST;
    addrs[4] = A_CTRL; addrs[5] = A_DCNT; addrs[6] = BASE + 32'h14; addrs[7] = BASE - 32'h4;
    idle();
    rnd_on = 1;
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        apb_read(addrs[$urandom_range(0, 7)], d);
        check("rnd_prdata", d, m_prdata);
      end else if (r <= 6) begin
        logic [31:0] w;
        w = {29'h0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
        apb_write(A_CTRL, w);
      end else if (r == 7) begin
        apb_write(addrs[$urandom_range(0, 7)], $urandom & 32'h1);
      end else begin
        idle();
      end
    end
    rnd_on = 0;
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
